// File: rtl/k6502_seq.sv
// Cycle sequencer and interrupt arbiter: one-hot microcode step plus RST/RUN/NMI/IRQ mode lines.
// Latency: cycle and mode lines update on the rising clk edge; ir_load is combinational in the boundary cycle.
// Backpressure: rdy=0 freezes step, mode and overrun flag; NMI edge capture keeps running.
module k6502_seq #(
    parameter int CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              next,
    input  logic              nmi_n,
    input  logic              irq_n,
    input  logic              i_flag,
    input  logic              rst_req,
    output logic [CYCLES-1:0] cycle,
    output logic              seq_rst,
    output logic              seq_nmi,
    output logic              seq_irq,
    output logic              ir_load,
    output logic              err_ovf
);

    typedef enum logic [1:0] {
        ST_RST = 2'd0,
        ST_RUN = 2'd1,
        ST_NMI = 2'd2,
        ST_IRQ = 2'd3
    } state_e;

    localparam logic [CYCLES-1:0] C0 = CYCLES'(1);

    state_e            state_q, state_d;
    logic [CYCLES-1:0] cycle_q, cycle_d;
    logic              seq_rst_q, seq_rst_d;
    logic              seq_nmi_q, seq_nmi_d;
    logic              seq_irq_q, seq_irq_d;
    logic              nmi_prev_q, nmi_prev_d;
    logic              nmi_pend_q, nmi_pend_d;
    logic              err_ovf_q, err_ovf_d;

    logic              boundary;
    logic              forced;
    logic              take;
    logic              nmi_fall;
    state_e            arb_state;

    // Boundary detection, priority arbitration and next-state computation.
    always_comb begin
        boundary   = next | cycle_q[CYCLES-1];
        forced     = cycle_q[CYCLES-1] & ~next;
        take       = rdy & boundary;
        nmi_fall   = nmi_prev_q & ~nmi_n;

        // Reset request beats NMI beats unmasked IRQ; every state arbitrates identically.
        if (rst_req)                arb_state = ST_RST;
        else if (nmi_pend_q)        arb_state = ST_NMI;
        else if (!irq_n && !i_flag) arb_state = ST_IRQ;
        else                        arb_state = ST_RUN;

        state_d    = take ? arb_state : state_q;

        cycle_d    = cycle_q;
        if (rdy) begin
            cycle_d = boundary ? C0 : (cycle_q << 1);
        end

        err_ovf_d  = err_ovf_q | (rdy & forced);

        // A fresh fall must survive an NMI entry on the same edge, so the set is applied last.
        nmi_pend_d = nmi_pend_q;
        if (take && (arb_state == ST_NMI)) begin
            nmi_pend_d = 1'b0;
        end
        if (nmi_fall) begin
            nmi_pend_d = 1'b1;
        end
        nmi_prev_d = nmi_n;

        seq_rst_d  = (state_d == ST_RST);
        seq_nmi_d  = (state_d == ST_NMI);
        seq_irq_d  = (state_d == ST_IRQ);

        // Opcode is fetched only when the boundary resumes normal execution; gated low during reset.
        ir_load    = rst_n & take & (arb_state == ST_RUN);
    end

    // State, step and flag registers; mode lines are flopped decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            cycle_q    <= C0;
            seq_rst_q  <= 1'b1;
            seq_nmi_q  <= 1'b0;
            seq_irq_q  <= 1'b0;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            seq_rst_q  <= seq_rst_d;
            seq_nmi_q  <= seq_nmi_d;
            seq_irq_q  <= seq_irq_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign cycle   = cycle_q;
    assign seq_rst = seq_rst_q;
    assign seq_nmi = seq_nmi_q;
    assign seq_irq = seq_irq_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_k6502_seq.sv
// Directed bench for k6502_seq: power-up, stalls, NMI/IRQ priority, masking, overrun, soft reset.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
// Every step advances a fixed number of clocks, so the run always terminates.
module tb_k6502_seq;

    localparam int CYCLES = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rdy;
    logic              next;
    logic              nmi_n;
    logic              irq_n;
    logic              i_flag;
    logic              rst_req;
    logic [CYCLES-1:0] cycle;
    logic              seq_rst;
    logic              seq_nmi;
    logic              seq_irq;
    logic              ir_load;
    logic              err_ovf;

    int total = 0;
    int bad   = 0;

    k6502_seq #(.CYCLES(CYCLES)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .next    (next),
        .nmi_n   (nmi_n),
        .irq_n   (irq_n),
        .i_flag  (i_flag),
        .rst_req (rst_req),
        .cycle   (cycle),
        .seq_rst (seq_rst),
        .seq_nmi (seq_nmi),
        .seq_irq (seq_irq),
        .ir_load (ir_load),
        .err_ovf (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode lines packed as {seq_rst, seq_nmi, seq_irq}.
    task automatic chk_mode(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, seq_rst, seq_nmi, seq_irq}, {29'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; next = 1'b1; nmi_n = 1'b1;
        irq_n = 1'b1; i_flag = 1'b1; rst_req = 1'b0;

        // Reset state, with next high to show ir_load is held off.
        repeat (3) tick();
        #1;
        chk("rst_cycle", cycle, 1);
        chk_mode("rst_mode", 3'b100);
        chk("rst_err", err_ovf, 0);
        chk("rst_irload", ir_load, 0);
        rst_n = 1'b1;

        // Power-up: RST sequence with NEXT at C_4.
        for (int k = 0; k < 5; k++) begin
            next = (k == 4);
            #1;
            chk("pu_cycle", cycle, 32'd1 << k);
            chk_mode("pu_mode", 3'b100);
            chk("pu_irload", ir_load, (k == 4) ? 1 : 0);
            tick();
        end
        chk("pu_end_cycle", cycle, 1);
        chk_mode("pu_end_mode", 3'b000);

        // Two-cycle instruction in RUN.
        for (int r = 0; r < 2; r++) begin
            next = 1'b0; #1;
            chk("inx_c0", cycle, 1);
            chk("inx_ir0", ir_load, 0);
            tick();
            next = 1'b1; #1;
            chk("inx_c1", cycle, 2);
            chk("inx_ir1", ir_load, 1);
            tick();
        end
        next = 1'b0; tick();
        rdy = 1'b0; next = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_ir", ir_load, 0);
            tick();
            chk("stall_cycle", cycle, 2);
        end
        rdy = 1'b1; #1;
        chk("stall_rel_ir", ir_load, 1);
        tick();
        chk("stall_rel_cycle", cycle, 1);

        // NMI beats IRQ; IRQ follows after the NMI sequence.
        next = 1'b0; nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
        tick();
        tick();
        chk("pri_c2", cycle, 4);
        next = 1'b1; #1;
        chk("pri_nmi_ir", ir_load, 0);
        tick();
        chk_mode("pri_nmi_mode", 3'b010);
        chk("pri_nmi_cycle", cycle, 1);
        next = 1'b0; tick(); tick();
        next = 1'b1; #1;
        chk("pri_irq_ir", ir_load, 0);
        tick();
        chk_mode("pri_irq_mode", 3'b001);
        irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b1;
        next = 1'b1; #1;
        chk("pri_ret_ir", ir_load, 1);
        tick();
        chk_mode("pri_ret_mode", 3'b000);

        // IRQ masking, unmasking before a boundary, and release before a boundary.
        irq_n = 1'b0; i_flag = 1'b1; next = 1'b1; #1;
        chk("mask_ir", ir_load, 1);
        tick();
        chk_mode("mask_mode", 3'b000);
        next = 1'b0; tick();
        i_flag = 1'b0; next = 1'b1; #1;
        chk("unmask_ir", ir_load, 0);
        tick();
        chk_mode("unmask_mode", 3'b001);
        irq_n = 1'b1; next = 1'b0; tick();
        next = 1'b1; #1;
        chk("irq_exit_ir", ir_load, 1);
        tick();
        chk_mode("irq_exit_mode", 3'b000);
        irq_n = 1'b0; next = 1'b0; tick();
        irq_n = 1'b1; next = 1'b1; #1;
        chk("drop_ir", ir_load, 1);
        tick();
        chk_mode("drop_mode", 3'b000);

        // Overrun: next held low walks all six steps then forces a boundary.
        next = 1'b0;
        for (int k = 0; k < CYCLES; k++) begin
            #1;
            chk("ovf_cycle", cycle, 32'd1 << k);
            chk("ovf_err_pre", err_ovf, 0);
            if (k == CYCLES - 1) chk("ovf_ir", ir_load, 1);
            tick();
        end
        chk("ovf_wrap", cycle, 1);
        chk("ovf_err", err_ovf, 1);
        chk_mode("ovf_mode", 3'b000);
        rdy = 1'b0; tick();
        chk("ovf_hold_cycle", cycle, 1);
        rdy = 1'b1; next = 1'b0; tick();
        next = 1'b1; tick();
        chk("ovf_sticky", err_ovf, 1);

        // Soft reset coinciding with a pending NMI: RST first, NMI retained.
        nmi_n = 1'b0; next = 1'b0; tick();
        rst_req = 1'b1; next = 1'b1; #1;
        chk("srst_ir", ir_load, 0);
        tick();
        chk_mode("srst_mode", 3'b100);
        rst_req = 1'b0; next = 1'b0; nmi_n = 1'b1; tick();
        next = 1'b1; #1;
        chk("srst_end_ir", ir_load, 0);
        tick();
        chk_mode("srst_nmi_mode", 3'b010);
        chk("srst_err_kept", err_ovf, 1);

        // A fall on the boundary cycle is serviced at the following boundary.
        next = 1'b0; tick();
        nmi_n = 1'b0; next = 1'b1; #1;
        chk("late_ir", ir_load, 1);
        tick();
        chk_mode("late_run_mode", 3'b000);
        #1;
        chk("late_nmi_ir", ir_load, 0);
        tick();
        chk_mode("late_nmi_mode", 3'b010);
        nmi_n = 1'b1; #1;
        chk("late_exit_ir", ir_load, 1);
        tick();
        chk_mode("late_exit_mode", 3'b000);

        // Fall on the same edge as NMI entry keeps the request pending.
        nmi_n = 1'b0; next = 1'b0; tick();
        nmi_n = 1'b1; tick();
        nmi_n = 1'b0; next = 1'b1; #1;
        chk("setwin_ir", ir_load, 0);
        tick();
        chk_mode("setwin_mode1", 3'b010);
        #1;
        chk("setwin_ir2", ir_load, 0);
        tick();
        chk_mode("setwin_mode2", 3'b010);
        nmi_n = 1'b1; #1;
        chk("setwin_exit_ir", ir_load, 1);
        tick();
        chk_mode("setwin_exit_mode", 3'b000);

        // NMI edge captured while rdy is low.
        rdy = 1'b0; nmi_n = 1'b0; tick();
        nmi_n = 1'b1; tick();
        chk("rdylo_cycle", cycle, 1);
        chk_mode("rdylo_mode", 3'b000);
        rdy = 1'b1; next = 1'b1; #1;
        chk("rdylo_ir", ir_load, 0);
        tick();
        chk_mode("rdylo_nmi_mode", 3'b010);
        #1;
        chk("rdylo_exit_ir", ir_load, 1);
        tick();
        chk_mode("rdylo_exit_mode", 3'b000);

        // Asynchronous reset mid-instruction.
        next = 1'b0; tick(); tick();
        chk("arst_pre_cycle", cycle, 4);
        #2;
        rst_n = 1'b0; next = 1'b1; #1;
        chk("arst_cycle", cycle, 1);
        chk_mode("arst_mode", 3'b100);
        chk("arst_err", err_ovf, 0);
        chk("arst_ir", ir_load, 0);
        tick();
        rst_n = 1'b1; #1;
        chk("arst_rel_ir", ir_load, 1);
        tick();
        chk_mode("arst_rel_mode", 3'b000);
        chk("arst_rel_err", err_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k6502_seq.md
# k6502_seq

Cycle sequencer and interrupt arbiter for the k6502 core, generalised to a parameterised microcode depth. It drives the one-hot `cycle` vector and the mutually exclusive `seq_rst`/`seq_nmi`/`seq_irq` mode lines consumed by the microcode decoder, and advances on the decoder's SYNC/NEXT bit. It also detects NMI edges, samples level IRQ against the I flag, arbitrates at instruction boundaries, strobes opcode load, and flags runaway microcode.

## Interface
- `CYCLES`, 6: width of the one-hot `cycle` vector, i.e. the maximum microcode steps per instruction; minimum 2.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  advance enable. Low stalls all state except NMI edge capture.
- `next`  in  1  SYNC/NEXT bit from the decoder for the current cycle.
- `nmi_n`  in  1  NMI pin, active-low, edge-triggered, already synchronous to `clk`.
- `irq_n`  in  1  IRQ pin, active-low, level-sensitive, already synchronous to `clk`.
- `i_flag`  in  1  processor I (interrupt disable) flag.
- `rst_req`  in  1  soft-reset request, level, taken at the next boundary.
- `cycle`  out  CYCLES  one-hot step; bit0 is C_0.
- `seq_rst`, `seq_nmi`, `seq_irq`  out  1 each  decoder mode lines, at most one high.
- `ir_load`  out  1  opcode capture strobe (combinational).
- `err_ovf`  out  1  sticky microcode-overrun flag.

## Operation
- States are RST, RUN, NMI and IRQ. `seq_rst`=(RST), `seq_nmi`=(NMI), `seq_irq`=(IRQ); all are registered decodes.
- Advance (`rdy`=1):
  - A boundary is taken when `next`=1, or when `cycle[CYCLES-1]`=1 with `next`=0 (forced boundary).
  - On a forced boundary, set `err_ovf`. It clears only on `rst_n`.
  - At a boundary, `cycle` goes to 1 (C_0). Otherwise `cycle` shifts left by one.
- Boundary arbitration, highest priority first:
  - `rst_req`=1 → RST.
  - `nmi_pend`=1 → NMI, and clear `nmi_pend` on that edge.
  - `irq_n`=0 && `i_flag`=0 → IRQ.
  - Otherwise → RUN.
  - All states use the same arbitration, so NMI can preempt the instruction following an IRQ entry.
- `ir_load` = `rdy` & boundary & (arbitrated next state == RUN). When the boundary enters an interrupt or reset, the IR is not reloaded.
- NMI edge detection:
  - `nmi_prev` register, reset value 1.
  - A falling edge (`nmi_prev`=1, `nmi_n`=0) sets `nmi_pend`. `nmi_prev` updates every clock, regardless of `rdy`.
  - If a fall and the NMI-entry clear land on the same edge, the set wins.
- Arbitration uses the registered `nmi_pend`. A fall on the boundary cycle itself is serviced at the following boundary.
- IRQ is sampled only at a boundary and is never latched. Deasserting it before a boundary drops the request.
- `rdy`=0 holds `cycle`, the state and `err_ovf`. `ir_load`=0.

## Timing
- Reset values while `rst_n`=0:
  - state=RST, so `seq_rst`=1, `seq_nmi`=0, `seq_irq`=0.
  - `cycle`=1, `nmi_pend`=0, `nmi_prev`=1, `err_ovf`=0.
  - `ir_load`=0.
- `rst_n` asserted mid-instruction immediately returns all of the above, asynchronously.
- `cycle` and the mode lines change only on a rising `clk` edge. The decoder sees the new step in the same cycle.
- Instruction length is N+1 clocks when NEXT is asserted at C_N.
- Interrupt latency from a boundary is 0 extra clocks: the mode line is high during the C_0 that follows the boundary.
- Minimum NMI latency from `nmi_n` fall is 1 clock to `nmi_pend`, then up to the remainder of the current instruction.

## Test plan
- Power-up sequence:
  - Stimulus: `rst_n` low 3 clocks then high, `rdy`=1, `next`=1 only at C_4.
  - Response: `seq_rst`=1 with `cycle` 01,02,04,08,10.
  - Then `cycle`=01, `seq_rst`=0, `ir_load`=1 on the C_4 clock.
- Two-cycle INX in RUN (`next` at C_1):
  - Response: `cycle` alternates 01,02. `ir_load` pulses every second clock.
  - With `rdy`=0 for 3 clocks at C_1: `cycle` holds 02 and `ir_load`=0.
- NMI/IRQ priority:
  - Stimulus: `nmi_n` falls and `irq_n`=0, `i_flag`=0, mid-instruction.
  - Response: the next boundary enters NMI (`seq_nmi`=1, `ir_load`=0) and `nmi_pend` clears.
  - The boundary after the NMI sequence enters IRQ.
- IRQ masking:
  - With `i_flag`=1 and `irq_n`=0: state stays RUN.
  - `i_flag`→0 before a boundary: IRQ is entered at that boundary.
  - `irq_n` released before a boundary: nothing is entered.
- Overrun with CYCLES=6 and `next` held 0:
  - Response: `cycle` runs 01..20, then returns to 01 with `err_ovf`=1 sticky, after a boundary taken as normal.
  - `err_ovf` clears only on `rst_n`.
- Soft reset and simultaneous events:
  - Stimulus: `rst_req`=1 coinciding with a pending NMI at a boundary.
  - Response: RST is entered and `nmi_pend` is retained. NMI is entered at the boundary ending the reset sequence.
